pipelined_divider: RTL and testbench
====================================

Name: pipelined_divider

Overview:
Parametrised successor to the team's fixed 32-bit restoring divider.
- Pipelined signed/unsigned fixed-point division: quotient = (dividend << FRAC_BITS) / divisor, plus remainder.
- Adds configurable radix per stage, a valid/ready backpressure handshake and a per-operation tag.
- Adds divide-by-zero and overflow reporting with saturation.
- Feeds the fluid solver's pressure/velocity normalisation datapath.

Parameters:
WIDTH, 32, operand/quotient/remainder width (≥4).
FRAC_BITS, 0, fractional bits in Q-format; numerator width N = WIDTH+FRAC_BITS.
BITS_PER_STAGE, 2, restoring iterations per register stage (1..4); S = ceil(N/BITS_PER_STAGE).
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
TAG_WIDTH, 4, width of sideband tag carried alongside each operation (≥1).

Ports:
clk_in  input  1  clock, all logic on rising edge.
rst_n_in  input  1  asynchronous active-low reset.
dividend_in  input  WIDTH  numerator (Q-format if FRAC_BITS>0).
divisor_in  input  WIDTH  denominator.
tag_in  input  TAG_WIDTH  sideband returned with the result.
data_valid_in  input  1  input operation valid.
ready_out  output  1  block can accept; transfer when data_valid_in && ready_out.
quotient_out  output  WIDTH  saturated quotient, truncated toward zero.
remainder_out  output  WIDTH  remainder; sign follows dividend.
tag_out  output  TAG_WIDTH  tag of the current result.
data_valid_out  output  1  result valid.
ready_in  input  1  downstream accepts; result retires when data_valid_out && ready_in.
error_out  output  1  divisor was zero (qualified by data_valid_out).
overflow_out  output  1  quotient saturated (qualified by data_valid_out).
busy_out  output  1  any valid operation in flight, including the output register.

Behaviour:
- Reset (async assert, sync deassert externally): all stage valids 0. quotient_out, remainder_out, tag_out = 0. data_valid_out, error_out, overflow_out, busy_out = 0. ready_out = 1 one cycle after deassert.
- Pipeline: stage 0 registers magnitudes |a|<<FRAC_BITS, |b|, result sign, dividend sign, zero-divisor flag, tag. Stages 1..S each perform BITS_PER_STAGE restoring steps (shift-in numerator MSB, compare with divisor, subtract, set quotient bit); the last stage handles N mod BITS_PER_STAGE. Final stage applies sign, saturation and flags into registered outputs.
- Latency: S+2 cycles accept-to-data_valid_out with no stall (defaults: S=16, latency 18). Throughput 1 op/cycle.
- Stall: advance = !data_valid_out || ready_in. On advance=0 every stage holds its contents; no bubbles are inserted and none are squeezed. ready_out = advance (combinational, no dependency on data_valid_in). Results are returned strictly in order.
- Signed arithmetic (SIGNED=1): magnitudes are computed with width WIDTH+1 so -2^(WIDTH-1) is handled. Quotient is negated when the operand signs differ. Remainder is negated when the dividend is negative.
- Overflow: if the true quotient magnitude exceeds the signed range (or 2^WIDTH-1 when unsigned), overflow_out=1 and the quotient saturates to max positive / min negative according to the result sign. Remainder is then unspecified but must be deterministic; it is 0.
- Divide by zero: error_out=1, overflow_out=0, remainder_out=dividend_in. Quotient = max positive if dividend ≥ 0, else min negative (unsigned mode: all-ones). 0/0 gives max positive.
- Unsigned mode: no negation; internal width N.
- Reset mid-operation: in-flight operations are discarded, no result emerges. First accept after reset behaves normally.
- busy_out = OR of all stage valids and data_valid_out.

Decomposition:
- Package divider_pkg holds:
  - function div_latency(WIDTH,FRAC_BITS,BITS_PER_STAGE) returning S+2;
  - sat_max/sat_min functions;
  - a packed typedef div_stage_t {valid, rem, num, quo, divisor, neg_q, neg_r, div0, tag}, parametrised via localparams in the module.
- One sub-module div_stage: combinational BITS_PER_STAGE restoring steps on div_stage_t. It is instantiated S times inside a generate loop; the registers live in pipelined_divider.

Test Plan:
- Defaults: 7/2 -> q=3 r=1; -7/2 -> q=-3 r=-1; 7/-2 -> q=-3 r=1. Each appears exactly 18 cycles after accept, tag echoed.
- FRAC_BITS=16, WIDTH=32: 0x00010000/0x00030000 -> q=0x00005555 r=0x00010000; 0xFFFF0000/0x00020000 -> q=0xFFFF8000.
- 5/0 -> q=0x7FFFFFFF, r=5, error_out=1. -5/0 -> q=0x80000000, error_out=1. 0x80000000/0xFFFFFFFF -> q=0x7FFFFFFF, overflow_out=1, r=0.
- Stream 40 random ops back-to-back with ready_in toggling (low 5 cycles, random thereafter) -> all 40 results in order, tags 0..39 mod 16 matching, values equal golden model, no duplicates.
- Assert rst_n_in low for 1 cycle with 10 ops in flight -> data_valid_out, busy_out low immediately. Next op 100/7 -> q=14 r=2 after 18 cycles.
- SIGNED=0, BITS_PER_STAGE=3, WIDTH=16: 0xFFFF/0x0003 -> q=0x5555 r=0, latency ceil(16/3)+2=8.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared sizing and saturation helpers for the pipelined fixed-point divider.
package divider_pkg;

    localparam int SAT_W = 64;

    function automatic int num_stages(input int width, input int frac_bits,
                                      input int bps);
        return (width + frac_bits + bps - 1) / bps;
    endfunction

    function automatic int div_latency(input int width, input int frac_bits,
                                       input int bps);
        return num_stages(width, frac_bits, bps) + 2;
    endfunction

    // Restoring steps done by 1-based stage s; the last one takes the leftover.
    function automatic int stage_steps(input int n, input int bps, input int s);
        int left;
        left = n - (s - 1) * bps;
        return (left < bps) ? left : bps;
    endfunction

    // valid + rem(W+1) + num(N) + quo(N) + divisor(W) + 3 flags + tag
    function automatic int stage_bits(input int width, input int frac_bits,
                                      input int tag_width);
        return 2 * width + 2 * (width + frac_bits) + tag_width + 5;
    endfunction

    function automatic logic [SAT_W-1:0] sat_max(input int width,
                                                 input logic is_signed);
        if (is_signed)
            return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        return (SAT_W'(1) << width) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int width,
                                                 input logic is_signed);
        if (is_signed)
            return SAT_W'(1) << (width - 1);
        return '0;
    endfunction

endpackage

// File: rtl/pipelined_divider_stage.sv
// Combinational block of restoring division steps between two pipeline registers.
module div_stage
    import divider_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0,
    parameter int STEPS     = 2,
    parameter int TAG_WIDTH = 4,
    localparam int N  = WIDTH + FRAC_BITS,
    localparam int SW = stage_bits(WIDTH, FRAC_BITS, TAG_WIDTH)
) (
    input  logic [SW-1:0] stage_i,
    output logic [SW-1:0] stage_o
);

    typedef struct packed {
        logic                 valid;
        logic [WIDTH:0]       rem;
        logic [N-1:0]         num;
        logic [N-1:0]         quo;
        logic [WIDTH-1:0]     divisor;
        logic                 neg_q;
        logic                 neg_r;
        logic                 div0;
        logic [TAG_WIDTH-1:0] tag;
    } div_stage_t;

    div_stage_t       s_in;
    div_stage_t       s_out;
    logic [WIDTH:0]   rem_v;
    logic [WIDTH:0]   dvs;
    logic [N-1:0]     num_v;
    logic [N-1:0]     quo_v;

    assign s_in    = stage_i;
    assign stage_o = s_out;

    // A zero divisor carries the raw dividend in rem, so it must pass untouched.
    always_comb begin
        s_out = s_in;
        rem_v = s_in.rem;
        num_v = s_in.num;
        quo_v = s_in.quo;
        dvs   = {1'b0, s_in.divisor};
        if (!s_in.div0) begin
            for (int k = 0; k < STEPS; k++) begin
                rem_v = {rem_v[WIDTH-1:0], num_v[N-1]};
                num_v = num_v << 1;
                quo_v = quo_v << 1;
                if (rem_v >= dvs) begin
                    rem_v    = rem_v - dvs;
                    quo_v[0] = 1'b1;
                end
            end
        end
        s_out.rem = rem_v;
        s_out.num = num_v;
        s_out.quo = quo_v;
    end

endmodule

// File: rtl/pipelined_divider.sv
// Pipelined signed/unsigned fixed-point divider with backpressure and tags.
module pipelined_divider
    import divider_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int FRAC_BITS      = 0,
    parameter int BITS_PER_STAGE = 2,
    parameter int SIGNED         = 1,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 data_valid_in,
    output logic                 ready_out,
    output logic [WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 data_valid_out,
    input  logic                 ready_in,
    output logic                 error_out,
    output logic                 overflow_out,
    output logic                 busy_out
);

    localparam int N  = WIDTH + FRAC_BITS;
    localparam int S  = num_stages(WIDTH, FRAC_BITS, BITS_PER_STAGE);
    localparam int SW = stage_bits(WIDTH, FRAC_BITS, TAG_WIDTH);

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(sat_max(WIDTH, SIGNED != 0));
    localparam logic [WIDTH-1:0] Q_MIN   = WIDTH'(sat_min(WIDTH, SIGNED != 0));
    localparam logic [N-1:0]     LIM_POS = N'(Q_MAX);
    localparam logic [N-1:0]     LIM_NEG = N'(Q_MIN);

    typedef struct packed {
        logic                 valid;
        logic [WIDTH:0]       rem;
        logic [N-1:0]         num;
        logic [N-1:0]         quo;
        logic [WIDTH-1:0]     divisor;
        logic                 neg_q;
        logic                 neg_r;
        logic                 div0;
        logic [TAG_WIDTH-1:0] tag;
    } div_stage_t;

    div_stage_t           s0_d;
    div_stage_t           st_q [0:S];
    logic [SW-1:0]        st_d [1:S];
    div_stage_t           last;
    logic                 advance;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH:0]       a_mag;
    logic [WIDTH:0]       b_mag;
    logic [N-1:0]         lim;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     quo_d, quo_q;
    logic [WIDTH-1:0]     rem_d, rem_q;
    logic                 err_d, err_q;
    logic                 ovf_d, ovf_q;
    logic                 valid_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 busy;
    logic                 unused_bits;

    assign advance   = !valid_q || ready_in;
    assign ready_out = advance;
    assign last      = st_q[S];

    always_comb begin
        a_neg = (SIGNED != 0) && dividend_in[WIDTH-1];
        b_neg = (SIGNED != 0) && divisor_in[WIDTH-1];
        a_mag = a_neg ? -{1'b1, dividend_in} : {1'b0, dividend_in};
        b_mag = b_neg ? -{1'b1, divisor_in} : {1'b0, divisor_in};
        s0_d          = '0;
        s0_d.valid    = data_valid_in;
        s0_d.tag      = tag_in;
        s0_d.neg_q    = a_neg ^ b_neg;
        s0_d.neg_r    = a_neg;
        s0_d.div0     = (divisor_in == '0);
        s0_d.divisor  = b_mag[WIDTH-1:0];
        if (s0_d.div0)
            s0_d.rem = {1'b0, dividend_in};
        else
            s0_d.num = N'(a_mag[WIDTH-1:0]) << FRAC_BITS;
    end

    for (genvar g = 1; g <= S; g++) begin : g_stage
        div_stage #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .STEPS     (stage_steps(N, BITS_PER_STAGE, g)),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_stage (
            .stage_i (st_q[g-1]),
            .stage_o (st_d[g])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i <= S; i++)
                st_q[i] <= '0;
        end else if (advance) begin
            st_q[0] <= s0_d;
            for (int i = 1; i <= S; i++)
                st_q[i] <= st_d[i];
        end
    end

    // Negative results may reach one further than positive ones.
    always_comb begin
        quo_d = '0;
        rem_d = '0;
        err_d = 1'b0;
        ovf_d = 1'b0;
        r_mag = last.rem[WIDTH-1:0];
        lim   = last.neg_q ? LIM_NEG : LIM_POS;
        if (last.div0) begin
            err_d = 1'b1;
            quo_d = last.neg_r ? Q_MIN : Q_MAX;
            rem_d = last.rem[WIDTH-1:0];
        end else if (last.quo > lim) begin
            ovf_d = 1'b1;
            quo_d = last.neg_q ? Q_MIN : Q_MAX;
        end else begin
            quo_d = last.neg_q ? -last.quo[WIDTH-1:0] : last.quo[WIDTH-1:0];
            rem_d = last.neg_r ? -r_mag : r_mag;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            valid_q <= last.valid;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            tag_q   <= last.tag;
            err_q   <= err_d & last.valid;
            ovf_q   <= ovf_d & last.valid;
        end
    end

    always_comb begin
        busy = valid_q;
        for (int i = 0; i <= S; i++)
            busy = busy | st_q[i].valid;
    end

    assign unused_bits = ^{last.num, last.divisor, last.rem[WIDTH],
                           a_mag[WIDTH], b_mag[WIDTH]};

    assign quotient_out   = quo_q;
    assign remainder_out  = rem_q;
    assign tag_out        = tag_q;
    assign data_valid_out = valid_q;
    assign error_out      = err_q;
    assign overflow_out   = ovf_q;
    assign busy_out       = busy;

endmodule

// File: tb/tb_pipelined_divider.sv
// Scoreboard bench for pipelined_divider: default, Q16.16 and unsigned radix-8 builds.
module tb_pipelined_divider;

    localparam int W   = 32;
    localparam int LAT = (W + 2 - 1) / 2 + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] a, b, q, r;
    logic [3:0]  tag_i, tag_o;
    logic        dvi, rdy_o, dvo, rdy_i, err, ovf, busy;

    logic [31:0] fa, fb, fq, fr;
    logic [3:0]  f_tag_o;
    logic        fdvi, f_rdy_o, fdvo, f_err, f_ovf, unused_f_busy;

    logic [15:0] ua, ub, uq, ur;
    logic [3:0]  u_tag_o;
    logic        udvi, u_rdy_o, udvo, u_err, u_ovf, unused_u_busy;

    logic        sec_rdy = 1'b1;
    logic [3:0]  sec_tag = 4'hA;

    pipelined_divider dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .dividend_in(a), .divisor_in(b), .tag_in(tag_i),
        .data_valid_in(dvi), .ready_out(rdy_o),
        .quotient_out(q), .remainder_out(r), .tag_out(tag_o),
        .data_valid_out(dvo), .ready_in(rdy_i),
        .error_out(err), .overflow_out(ovf), .busy_out(busy)
    );

    pipelined_divider #(.WIDTH(32), .FRAC_BITS(16), .BITS_PER_STAGE(2),
                        .SIGNED(1), .TAG_WIDTH(4)) dut_f (
        .clk_in(clk), .rst_n_in(rst_n),
        .dividend_in(fa), .divisor_in(fb), .tag_in(sec_tag),
        .data_valid_in(fdvi), .ready_out(f_rdy_o),
        .quotient_out(fq), .remainder_out(fr), .tag_out(f_tag_o),
        .data_valid_out(fdvo), .ready_in(sec_rdy),
        .error_out(f_err), .overflow_out(f_ovf), .busy_out(unused_f_busy)
    );

    pipelined_divider #(.WIDTH(16), .FRAC_BITS(0), .BITS_PER_STAGE(3),
                        .SIGNED(0), .TAG_WIDTH(4)) dut_u (
        .clk_in(clk), .rst_n_in(rst_n),
        .dividend_in(ua), .divisor_in(ub), .tag_in(sec_tag),
        .data_valid_in(udvi), .ready_out(u_rdy_o),
        .quotient_out(uq), .remainder_out(ur), .tag_out(u_tag_o),
        .data_valid_out(udvo), .ready_in(sec_rdy),
        .error_out(u_err), .overflow_out(u_ovf), .busy_out(unused_u_busy)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        logic        ovf;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   stream_done = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer division of (dividend * 2^f) by divisor.
    function automatic void model(input int w, input int f, input bit sgn,
                                  input logic [63:0] ar, input logic [63:0] br,
                                  output logic [63:0] mq, output logic [63:0] mr,
                                  output bit er, output bit ov);
        longint av, bv, num, qq, rr, maxp, minn;
        av = longint'(ar);
        bv = longint'(br);
        if (sgn && ar[w-1]) av = av - (longint'(1) << w);
        if (sgn && br[w-1]) bv = bv - (longint'(1) << w);
        maxp = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        minn = sgn ? -(longint'(1) << (w - 1)) : 0;
        er = 0;
        ov = 0;
        if (bv == 0) begin
            er = 1;
            mq = (av < 0) ? minn : maxp;
            mr = av;
        end else begin
            num = av * (longint'(1) << f);
            qq  = num / bv;
            rr  = num % bv;
            if (qq > maxp || qq < minn) begin
                ov = 1;
                mq = (qq > 0) ? maxp : minn;
                mr = 0;
            end else begin
                mq = qq;
                mr = rr;
            end
        end
    endfunction

    task automatic send(input logic [31:0] da, input logic [31:0] db,
                        input logic [3:0] tg, input bit lat);
        exp_t e;
        logic [63:0] mq, mr;
        bit me, mo;
        model(W, 0, 1'b1, {32'b0, da}, {32'b0, db}, mq, mr, me, mo);
        e.q = mq[31:0];
        e.r = mr[31:0];
        e.err = me;
        e.ovf = mo;
        e.tag = tg;
        e.lat = lat;
        a = da;
        b = db;
        tag_i = tg;
        dvi = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy_o) begin
                e.cyc = cyc;
                sbq.push_back(e);
                @(posedge clk);
                #1;
                dvi = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: tag %0d not accepted within 200 cycles", tg);
        dvi = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (sbq.size() == 0) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && dvo && rdy_i) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag %0d, expected no result", tag_o);
            end else begin
                e = sbq.pop_front();
                chk("quotient", {32'b0, q}, {32'b0, e.q});
                chk("remainder", {32'b0, r}, {32'b0, e.r});
                chk("tag", {60'b0, tag_o}, {60'b0, e.tag});
                chk("error_flag", {63'b0, err}, {63'b0, e.err});
                chk("overflow_flag", {63'b0, ovf}, {63'b0, e.ovf});
                if (e.lat)
                    chk("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
    end

    // One directed op on a secondary build; it idles otherwise.
    task automatic run_sec(input bit uns, input logic [31:0] da,
                           input logic [31:0] db, input string nm);
        logic [63:0] mq, mr, gq, gr, msk;
        bit me, mo, seen;
        logic ge, go, gt;
        int t0, lat;
        if (uns) begin
            model(16, 0, 1'b0, {48'b0, da[15:0]}, {48'b0, db[15:0]}, mq, mr, me, mo);
            lat = (16 + 3 - 1) / 3 + 2;
            msk = 64'h0000_0000_0000_FFFF;
            ua = da[15:0];
            ub = db[15:0];
            udvi = 1'b1;
            gt = u_rdy_o;
        end else begin
            model(32, 16, 1'b1, {32'b0, da}, {32'b0, db}, mq, mr, me, mo);
            lat = (48 + 2 - 1) / 2 + 2;
            msk = 64'h0000_0000_FFFF_FFFF;
            fa = da;
            fb = db;
            fdvi = 1'b1;
            gt = f_rdy_o;
        end
        t0 = cyc;
        chk({nm, "_ready"}, {63'b0, gt}, 64'd1);
        @(posedge clk);
        #1;
        udvi = 1'b0;
        fdvi = 1'b0;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (uns ? udvo : fdvo) begin
                seen = 1;
                gq = uns ? {48'b0, uq} : {32'b0, fq};
                gr = uns ? {48'b0, ur} : {32'b0, fr};
                ge = uns ? u_err : f_err;
                go = uns ? u_ovf : f_ovf;
                chk({nm, "_latency"}, 64'(cyc - t0), 64'(lat));
                chk({nm, "_q"}, gq, mq & msk);
                chk({nm, "_r"}, gr, mr & msk);
                chk({nm, "_err"}, {63'b0, ge}, {63'b0, me});
                chk({nm, "_ovf"}, {63'b0, go}, {63'b0, mo});
                chk({nm, "_tag"}, {60'b0, (uns ? u_tag_o : f_tag_o)}, {60'b0, sec_tag});
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no result within 60 cycles, expected one", nm);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        a = '0; b = '0; tag_i = '0; dvi = 1'b0; rdy_i = 1'b1;
        fa = '0; fb = '0; fdvi = 1'b0;
        ua = '0; ub = '0; udvi = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, dvo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_quotient", {32'b0, q}, 64'd0);
        chk("rst_remainder", {32'b0, r}, 64'd0);
        chk("rst_tag", {60'b0, tag_o}, 64'd0);
        chk("rst_err_ovf", {62'b0, err, ovf}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {63'b0, rdy_o}, 64'd1);

        send(32'd7, 32'd2, 4'd1, 1'b1);
        send(-32'sd7, 32'd2, 4'd2, 1'b1);
        send(32'd7, -32'sd2, 4'd3, 1'b1);
        send(32'd5, 32'd0, 4'd4, 1'b1);
        send(-32'sd5, 32'd0, 4'd5, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 1'b1);
        send(32'd0, 32'd0, 4'd7, 1'b1);
        send(32'h7FFF_FFFF, 32'h8000_0000, 4'd8, 1'b1);
        drain();
        chk("idle_busy", {63'b0, busy}, 64'd0);

        fork
            begin
                rdy_i = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                while (!stream_done) begin
                    rdy_i = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                rdy_i = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 5))
                        0: ra = 32'h8000_0000;
                        1: ra = $urandom_range(0, 100);
                        default: ra = $urandom;
                    endcase
                    case ($urandom_range(0, 7))
                        0: rb = 32'd0;
                        1: rb = 32'hFFFF_FFFF;
                        2: rb = $urandom_range(1, 9);
                        3: rb = -$urandom_range(1, 9);
                        default: rb = $urandom;
                    endcase
                    send(ra, rb, 4'(i), 1'b0);
                end
                stream_done = 1;
            end
        join
        drain();
        chk("stream_busy", {63'b0, busy}, 64'd0);

        for (int i = 0; i < 10; i++)
            send(32'(i * 3 + 1), 32'd3, 4'(i), 1'b0);
        chk("inflight_busy", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, dvo}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'd100, 32'd7, 4'd9, 1'b1);
        drain();

        run_sec(1'b0, 32'h0001_0000, 32'h0003_0000, "q16_third");
        run_sec(1'b0, 32'hFFFF_0000, 32'h0002_0000, "q16_neg_half");
        run_sec(1'b0, 32'h0005_0000, 32'h0000_0000, "q16_div0");
        run_sec(1'b0, 32'h7FFF_0000, 32'h0000_0100, "q16_ovf");
        run_sec(1'b1, 32'h0000_FFFF, 32'h0000_0003, "u16_max_by3");
        run_sec(1'b1, 32'h0000_1234, 32'h0000_0000, "u16_div0");
        run_sec(1'b1, 32'h0000_03E8, 32'h0000_0007, "u16_1000_by7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
